fa1: RTL and testbench



---
 rtl/fa_cell.sv | 13 +
 rtl/fa1.sv | 44 ++++
 tb/tb_fa1.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/fa_cell.sv
// Single-bit full adder, the leaf cell of the ripple-carry chain in fa1.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/fa1.sv
// WIDTH-bit ripple-carry adder with combinational Sum/Cout and a registered copy of both.
// Sum/Cout ignore clk and rst_n entirely; only Sum_q/Cout_q see the synchronous reset.
module fa1 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic [WIDTH-1:0] Sum_q,
  output logic             Cout_q
);

  // carry[i] feeds cell i; carry[WIDTH] is the final carry-out.
  logic [WIDTH:0] carry;

  assign carry[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fa_cell u_cell (
      .a  (A[i]),
      .b  (B[i]),
      .ci (carry[i]),
      .s  (Sum[i]),
      .co (carry[i+1])
    );
  end

  assign Cout = carry[WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Sum_q  <= '0;
      Cout_q <= 1'b0;
    end else begin
      Sum_q  <= Sum;
      Cout_q <= Cout;
    end
  end

endmodule

// File: tb/tb_fa1.sv
// Self-checking bench for fa1: WIDTH=1 and WIDTH=8 instances against an arithmetic model.
module tb_fa1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=1 instance
  logic       rst1_n;
  logic [0:0] a1, b1, s1, sq1;
  logic       c1, co1, coq1;

  fa1 #(.WIDTH(1)) u_dut1 (
    .clk    (clk),
    .rst_n  (rst1_n),
    .A      (a1),
    .B      (b1),
    .Cin    (c1),
    .Sum    (s1),
    .Cout   (co1),
    .Sum_q  (sq1),
    .Cout_q (coq1)
  );

  // WIDTH=8 instance
  logic       rst8_n;
  logic [7:0] a8, b8, s8, sq8;
  logic       c8, co8, coq8;

  fa1 #(.WIDTH(8)) u_dut8 (
    .clk    (clk),
    .rst_n  (rst8_n),
    .A      (a8),
    .B      (b8),
    .Cin    (c8),
    .Sum    (s8),
    .Cout   (co8),
    .Sum_q  (sq8),
    .Cout_q (coq8)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [8:0] exp;  // {Cout, Sum}
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at t=%0t", name, got, exp, $time);
    end
  endtask

  initial begin
    vec_t       t1[6];
    vec_t       t8[4];
    logic [8:0] ref_sum;
    logic [8:0] exp_q;
    logic       rnd_rst;

    // Walk sequence from the test plan: {Cout,Sum} per step 00,01,10,11,10,01.
    t1[0] = '{a: 8'd0, b: 8'd0, cin: 1'b0, exp: 9'b00};
    t1[1] = '{a: 8'd0, b: 8'd0, cin: 1'b1, exp: 9'b01};
    t1[2] = '{a: 8'd0, b: 8'd1, cin: 1'b1, exp: 9'b10};
    t1[3] = '{a: 8'd1, b: 8'd1, cin: 1'b1, exp: 9'b11};
    t1[4] = '{a: 8'd1, b: 8'd0, cin: 1'b1, exp: 9'b10};
    t1[5] = '{a: 8'd1, b: 8'd0, cin: 1'b0, exp: 9'b01};

    t8[0] = '{a: 8'hFF, b: 8'h00, cin: 1'b1, exp: 9'h100};
    t8[1] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, exp: 9'h1FF};
    t8[2] = '{a: 8'h00, b: 8'h00, cin: 1'b0, exp: 9'h000};
    t8[3] = '{a: 8'h80, b: 8'h80, cin: 1'b0, exp: 9'h100};

    rst1_n = 1'b0; rst8_n = 1'b0;
    a1 = '0; b1 = '0; c1 = 1'b0;
    a8 = '0; b8 = '0; c8 = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("w1_reset_q", {7'd0, coq1, sq1}, 9'd0);
    check("w8_reset_q", {coq8, sq8}, 9'd0);

    // Combinational path is live while reset is held low.
    foreach (t1[i]) begin
      @(negedge clk);
      a1 = t1[i].a[0:0]; b1 = t1[i].b[0:0]; c1 = t1[i].cin;
      #1;
      check($sformatf("w1_step%0d", i), {7'd0, co1, s1}, t1[i].exp);
    end
    check("w1_q_held_in_reset", {7'd0, coq1, sq1}, 9'd0);

    // Exhaustive: Sum = parity, Cout = majority.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = i[2:0];
      a1 = v[2:2]; b1 = v[1:1]; c1 = v[0];
      #1;
      ref_sum = 9'(v[2]) + 9'(v[1]) + 9'(v[0]);
      check($sformatf("w1_exh%0d", i), {7'd0, co1, s1}, ref_sum);
    end

    // Registered path: release reset with 1+1+1, then drop reset mid-stream.
    @(negedge clk);
    rst1_n = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    @(posedge clk); #1;
    check("w1_q_load", {7'd0, coq1, sq1}, 9'b11);
    @(negedge clk);
    rst1_n = 1'b0;
    @(posedge clk); #1;
    check("w1_q_midreset", {7'd0, coq1, sq1}, 9'b00);
    check("w1_comb_in_reset", {7'd0, co1, s1}, 9'b11);
    @(negedge clk);
    rst1_n = 1'b1;
    @(posedge clk); #1;
    check("w1_q_reload", {7'd0, coq1, sq1}, 9'b11);

    // WIDTH=8 directed boundaries.
    foreach (t8[i]) begin
      @(negedge clk);
      a8 = t8[i].a; b8 = t8[i].b; c8 = t8[i].cin;
      #1;
      check($sformatf("w8_dir%0d", i), {co8, s8}, t8[i].exp);
    end

    // WIDTH=8 random, with occasional reset pulses on the registered path.
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      rnd_rst = ($urandom_range(0, 15) == 0);
      rst8_n = ~rnd_rst;
      #1;
      ref_sum = 9'(a8) + 9'(b8) + 9'(c8);
      check("w8_rand_comb", {co8, s8}, ref_sum);
      exp_q = rnd_rst ? 9'd0 : ref_sum;
      @(posedge clk); #1;
      check("w8_rand_q", {coq8, sq8}, exp_q);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
